// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants and types for the seven-segment display path.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int SEG_W = 7;

    // Active-low {G,F,E,D,C,B,A}; leftmost entry is nibble F, rightmost is 0.
    localparam logic [15:0][SEG_W-1:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic [0:0] {
        SLOT_BLANK = 1'b0,
        SLOT_DRIVE = 1'b1
    } slot_state_e;

endpackage
`default_nettype wire

// File: rtl/seg_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_hex_decoder
// Description : Combinational hex nibble to active-low segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg_n
);

    assign seg_n = SEG_LUT[nibble];

endmodule
`default_nettype wire

// File: rtl/seg_mux_display.sv
`default_nettype none
// ============================================================================
// Module      : seg_mux_display
// Description : Time-multiplexed common-anode seven-segment driver with
//               blanking guard and frame-boundary (tear-free) frame updates.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_mux_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [SEG_W-1:0]        seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [IW-1:0] c_idx_last = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] c_cnt_last = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] c_blank    = CW'(BLANK_CYCLES);

    // Scan position and run flag (holds cnt at 0 for one cycle after reset)
    logic                    r_run;
    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    slot_state_e             r_slot;

    logic [4*NUM_DIGITS-1:0] r_pend_digits, r_act_digits;
    logic [NUM_DIGITS-1:0]   r_pend_dp,     r_act_dp;
    logic [NUM_DIGITS-1:0]   r_pend_en,     r_act_en;
    logic                    r_pend_valid;

    logic [NUM_DIGITS-1:0]   r_an;
    logic [SEG_W-1:0]        r_seg;
    logic                    r_dp_n;
    logic                    r_frame_start;

    logic                    w_boundary;
    logic [CW-1:0]           w_cnt_nxt;
    logic [IW-1:0]           w_idx_nxt;
    slot_state_e             w_slot_nxt;
    logic [4*NUM_DIGITS-1:0] w_pend_digits_nxt, w_act_digits_nxt;
    logic [NUM_DIGITS-1:0]   w_pend_dp_nxt,     w_act_dp_nxt;
    logic [NUM_DIGITS-1:0]   w_pend_en_nxt,     w_act_en_nxt;
    logic                    w_pend_valid_nxt;
    logic [IW+1:0]           w_sel;
    logic [3:0]              w_nibble;
    logic [SEG_W-1:0]        w_dec;
    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic [SEG_W-1:0]        w_seg_nxt;
    logic                    w_dp_n_nxt;
    logic                    w_frame_start_nxt;

    // Next scan position, frame registers and slot state
    always_comb begin
        w_boundary        = r_run && (r_cnt == c_cnt_last) && (r_idx == c_idx_last);
        w_cnt_nxt         = r_cnt;
        w_idx_nxt         = r_idx;
        w_pend_digits_nxt = r_pend_digits;
        w_pend_dp_nxt     = r_pend_dp;
        w_pend_en_nxt     = r_pend_en;
        w_pend_valid_nxt  = r_pend_valid;
        w_act_digits_nxt  = r_act_digits;
        w_act_dp_nxt      = r_act_dp;
        w_act_en_nxt      = r_act_en;

        if (r_run) begin
            if (r_cnt == c_cnt_last) begin
                w_cnt_nxt = '0;
                w_idx_nxt = (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end

        if (load) begin
            w_pend_digits_nxt = digits;
            w_pend_dp_nxt     = dp;
            w_pend_en_nxt     = digit_en;
            w_pend_valid_nxt  = 1'b1;
        end

        // A load arriving on the boundary bypasses pending entirely
        if (w_boundary) begin
            w_pend_valid_nxt = 1'b0;
            if (load) begin
                w_act_digits_nxt = digits;
                w_act_dp_nxt     = dp;
                w_act_en_nxt     = digit_en;
            end else if (r_pend_valid) begin
                w_act_digits_nxt = r_pend_digits;
                w_act_dp_nxt     = r_pend_dp;
                w_act_en_nxt     = r_pend_en;
            end
        end

        w_slot_nxt = (w_cnt_nxt < c_blank) ? SLOT_BLANK : SLOT_DRIVE;
    end

    assign w_sel    = {w_idx_nxt, 2'b00};
    assign w_nibble = w_act_digits_nxt[w_sel +: 4];

    seg_hex_decoder u_dec (
        .nibble (w_nibble),
        .seg_n  (w_dec)
    );

    // Output values are built from next-state so they line up with cnt
    always_comb begin
        w_an_nxt          = '1;
        w_seg_nxt         = SEG_BLANK;
        w_dp_n_nxt        = 1'b1;
        w_frame_start_nxt = (w_idx_nxt == '0) && (w_cnt_nxt == '0);
        if (w_slot_nxt == SLOT_DRIVE && w_act_en_nxt[w_idx_nxt]) begin
            w_an_nxt[w_idx_nxt] = 1'b0;
            w_seg_nxt           = w_dec;
            w_dp_n_nxt          = ~w_act_dp_nxt[w_idx_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run         <= 1'b0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_slot        <= SLOT_BLANK;
            r_pend_digits <= '0;
            r_pend_dp     <= '0;
            r_pend_en     <= '0;
            r_pend_valid  <= 1'b0;
            r_act_digits  <= '0;
            r_act_dp      <= '0;
            r_act_en      <= '0;
            r_an          <= '1;
            r_seg         <= SEG_BLANK;
            r_dp_n        <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_run         <= 1'b1;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_slot        <= w_slot_nxt;
            r_pend_digits <= w_pend_digits_nxt;
            r_pend_dp     <= w_pend_dp_nxt;
            r_pend_en     <= w_pend_en_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_act_digits  <= w_act_digits_nxt;
            r_act_dp      <= w_act_dp_nxt;
            r_act_en      <= w_act_en_nxt;
            r_an          <= w_an_nxt;
            r_seg         <= w_seg_nxt;
            r_dp_n        <= w_dp_n_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp_n        = r_dp_n;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
